// File: rtl/neural_dense_engine.sv
// rtl/neural_dense_engine.sv - dense layer core: sequential signed MAC over inputs, all neurons in parallel, ReLU, saturation
module neural_dense_engine #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16,
  localparam int ACC_W = 2*DATA_W + $clog2(N_IN) + 1,
  localparam int AW    = $clog2(N_OUT*N_IN + N_OUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              input_valid,
  output logic              input_ready,
  input  logic [DATA_W-1:0] input_data [N_IN],
  input  logic              relu_en,
  output logic              output_valid,
  input  logic              output_ready,
  output logic [OUT_W-1:0]  output_data [N_OUT],
  output logic [N_OUT-1:0]  output_sat,
  input  logic              w_we,
  input  logic [AW-1:0]     w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_ready
);

  localparam int N_W   = N_OUT*N_IN;
  localparam int N_REG = N_W + N_OUT;
  localparam int IDX_W = $clog2(N_IN);
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                    state, state_next;
  logic [IDX_W-1:0]          idx;
  logic signed [DATA_W-1:0]  x_q [N_IN];
  logic                      relu_q;
  logic signed [ACC_W-1:0]   acc [N_OUT];
  logic signed [DATA_W-1:0]  wmem [N_REG];
  logic                      hs_wr_vld;
  logic [AW-1:0]             hs_wr_addr;
  logic signed [DATA_W-1:0]  hs_wr_old;

  logic                      accept;
  logic                      wr_en;
  logic signed [DATA_W-1:0]  x_sel;
  logic [AW-1:0]             w_rd_addr [N_OUT];
  logic signed [DATA_W-1:0]  w_sel [N_OUT];
  logic signed [2*DATA_W-1:0] prod [N_OUT];
  logic signed [ACC_W-1:0]   v [N_OUT];

  assign input_ready  = (state == S_IDLE) && !rst;
  assign w_ready      = (state == S_IDLE) && !rst;
  assign output_valid = (state == S_OUT);
  assign accept       = input_valid && input_ready;
  assign wr_en        = w_we && w_ready && (int'(w_addr) < N_REG);
  assign x_sel        = x_q[idx];

  // A weight overwritten in the accept cycle is replayed from hs_wr_old so the
  // in-flight vector still sees the value that was current when it was accepted.
  always_comb begin
    for (int o = 0; o < N_OUT; o++) begin
      w_rd_addr[o] = AW'(o*N_IN) + AW'(idx);
      w_sel[o]     = wmem[w_rd_addr[o]];
      if (hs_wr_vld && (hs_wr_addr == w_rd_addr[o])) w_sel[o] = hs_wr_old;
      prod[o]      = x_sel * w_sel[o];
    end
  end

  always_comb begin
    for (int o = 0; o < N_OUT; o++) begin
      output_data[o] = '0;
      output_sat[o]  = 1'b0;
      v[o]           = (relu_q && (acc[o] < 0)) ? '0 : acc[o];
      if (state == S_OUT) begin
        if (v[o] > OUT_MAX) begin
          output_data[o] = OUT_MAX[OUT_W-1:0];
          output_sat[o]  = 1'b1;
        end else if (v[o] < OUT_MIN) begin
          output_data[o] = OUT_MIN[OUT_W-1:0];
          output_sat[o]  = 1'b1;
        end else begin
          output_data[o] = v[o][OUT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_MAC;
      S_MAC:   if (idx == IDX_W'(N_IN-1)) state_next = S_OUT;
      S_OUT:   if (output_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      relu_q     <= 1'b0;
      hs_wr_vld  <= 1'b0;
      hs_wr_addr <= '0;
      hs_wr_old  <= '0;
      for (int i = 0; i < N_IN; i++)  x_q[i]  <= '0;
      for (int o = 0; o < N_OUT; o++) acc[o]  <= '0;
      for (int r = 0; r < N_REG; r++) wmem[r] <= '0;
    end else begin
      if (wr_en) wmem[w_addr] <= w_data;
      case (state)
        S_IDLE: begin
          if (accept) begin
            for (int i = 0; i < N_IN; i++)  x_q[i] <= input_data[i];
            for (int o = 0; o < N_OUT; o++) acc[o] <= ACC_W'(wmem[AW'(N_W+o)]);
            relu_q     <= relu_en;
            idx        <= '0;
            hs_wr_vld  <= wr_en;
            hs_wr_addr <= w_addr;
            hs_wr_old  <= wmem[w_addr];
          end
        end
        S_MAC: begin
          for (int o = 0; o < N_OUT; o++) acc[o] <= acc[o] + ACC_W'(prod[o]);
          idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neural_dense_engine.sv
// tb/tb_neural_dense_engine.sv - directed bench for neural_dense_engine (N_IN=4, N_OUT=2, DATA_W=8, OUT_W=16)
module tb_neural_dense_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        input_valid = 1'b0;
  logic        input_ready;
  logic [7:0]  input_data [4];
  logic        relu_en = 1'b0;
  logic        output_valid;
  logic        output_ready = 1'b0;
  logic [15:0] output_data [2];
  logic [1:0]  output_sat;
  logic        w_we = 1'b0;
  logic [3:0]  w_addr = '0;
  logic [7:0]  w_data = '0;
  logic        w_ready;

  int errors = 0;
  int checks = 0;

  neural_dense_engine #(.N_IN(4), .N_OUT(2), .DATA_W(8), .OUT_W(16)) dut (
    .clk(clk), .rst(rst),
    .input_valid(input_valid), .input_ready(input_ready), .input_data(input_data), .relu_en(relu_en),
    .output_valid(output_valid), .output_ready(output_ready), .output_data(output_data), .output_sat(output_sat),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .w_ready(w_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    w_addr = 4'(a);
    w_data = 8'(d);
    w_we   = 1'b1;
    step();
    w_we   = 1'b0;
  endtask

  task automatic send(input int x0, input int x1, input int x2, input int x3, input logic relu);
    input_data[0] = 8'(x0);
    input_data[1] = 8'(x1);
    input_data[2] = 8'(x2);
    input_data[3] = 8'(x3);
    relu_en       = relu;
    input_valid   = 1'b1;
    chk("accept_ready", {31'b0, input_ready}, 32'd1);
    step();
    input_valid   = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int cnt = 0;
    while (!output_valid && cnt < 20) begin
      step();
      cnt++;
    end
    chk({tag, "_latency"}, cnt, 32'd4);
  endtask

  task automatic check_out(input string tag, input int e0, input int e1, input logic s0, input logic s1);
    logic [15:0] x0, x1;
    x0 = 16'(e0);
    x1 = 16'(e1);
    chk({tag, "_d0"}, {16'b0, output_data[0]}, {16'b0, x0});
    chk({tag, "_d1"}, {16'b0, output_data[1]}, {16'b0, x1});
    chk({tag, "_sat"}, {30'b0, output_sat}, {30'b0, s1, s0});
  endtask

  task automatic take_out(input string tag);
    output_ready = 1'b1;
    step();
    output_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'b0, output_valid}, 32'd0);
    chk({tag, "_d0_idle"}, {16'b0, output_data[0]}, 32'd0);
  endtask

  task automatic run(input string tag, input int x, input logic relu,
                     input int e0, input int e1, input logic s0, input logic s1);
    send(x, x, x, x, relu);
    wait_out(tag);
    check_out(tag, e0, e1, s0, s1);
    take_out(tag);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) input_data[i] = '0;

    // reset held three cycles
    repeat (3) begin
      step();
      chk("rst_ready", {31'b0, input_ready}, 32'd0);
      chk("rst_valid", {31'b0, output_valid}, 32'd0);
    end
    rst = 1'b0;
    step();
    chk("post_rst_ready", {31'b0, input_ready}, 32'd1);
    chk("post_rst_wready", {31'b0, w_ready}, 32'd1);
    chk("post_rst_d0", {16'b0, output_data[0]}, 32'd0);
    chk("post_rst_sat", {30'b0, output_sat}, 32'd0);
    run("rst_vec", 1, 1'b0, 0, 0, 1'b0, 1'b0);

    // W0=[1,2,3,4], W1=[-1,-1,-1,-1], b=[0,10]
    for (int i = 0; i < 4; i++) wr(i, i + 1);
    for (int i = 4; i < 8; i++) wr(i, -1);
    wr(8, 0);
    wr(9, 10);
    wr(15, 77);
    run("basic", 1, 1'b0, 10, 6, 1'b0, 1'b0);
    run("relu_on", -1, 1'b1, 0, 14, 1'b0, 1'b0);
    run("relu_off", -1, 1'b0, -10, 14, 1'b0, 1'b0);

    // weight write in the accept cycle commits but is not used by that vector
    w_addr = 4'd0;
    w_data = 8'd5;
    w_we   = 1'b1;
    send(1, 1, 1, 1, 1'b0);
    w_we   = 1'b0;
    wait_out("samecyc");
    check_out("samecyc", 10, 6, 1'b0, 1'b0);
    take_out("samecyc");
    run("samecyc_next", 1, 1'b0, 14, 6, 1'b0, 1'b0);
    wr(0, 1);

    // backpressure: output held, input and writes refused
    send(1, 1, 1, 1, 1'b0);
    wait_out("bp");
    input_valid = 1'b1;
    w_addr = 4'd0;
    w_data = 8'd100;
    w_we   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check_out("bp_hold", 10, 6, 1'b0, 1'b0);
      chk("bp_valid", {31'b0, output_valid}, 32'd1);
      chk("bp_in_ready", {31'b0, input_ready}, 32'd0);
      chk("bp_w_ready", {31'b0, w_ready}, 32'd0);
      step();
    end
    input_valid = 1'b0;
    w_we = 1'b0;
    take_out("bp");
    run("bp_readback", 1, 1'b0, 10, 6, 1'b0, 1'b0);

    // saturation: W0 all 127, W1 all -128, biases 0
    for (int i = 0; i < 4; i++) wr(i, 127);
    for (int i = 4; i < 8; i++) wr(i, -128);
    wr(9, 0);
    run("sat", 127, 1'b0, 32767, -32768, 1'b1, 1'b1);
    run("sat_relu", 127, 1'b1, 32767, 0, 1'b1, 1'b0);

    // reset during the second MAC cycle
    send(1, 1, 1, 1, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    begin
      int seen = 0;
      for (int c = 0; c < 8; c++) begin
        if (output_valid) seen++;
        step();
      end
      chk("rst_mid_no_valid", seen, 32'd0);
    end
    run("rst_mid_cleared", 5, 1'b0, 0, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
